// File: rtl/serial_latch_tx.sv
// ============================================================================
// Module   : serial_latch_tx
// Purpose  : Serialises a WIDTH-bit word MSB first onto d, with a one-cycle
//            en strobe per bit for a downstream gated D latch. d is set up
//            one full cycle before each strobe and held through it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_latch_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             d,
  output logic             en,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q;
  // The MSB of the frame is held in d_q itself, so the shift register
  // only needs to keep the WIDTH-1 bits still to be sent.
  logic [WIDTH-2:0]   shreg_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               d_q;
  logic               en_q;
  logic               busy_q;
  logic               done_q;

  // Frame sequencer; every output is computed for the state being entered,
  // so all ports come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shreg_q <= data_in[WIDTH-2:0];
            cnt_q   <= CNT_LOAD;
            d_q     <= data_in[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          // d is already stable; open the latch for exactly one cycle.
          en_q    <= 1'b1;
          state_q <= S_STROBE;
        end
        S_STROBE: begin
          en_q <= 1'b0;
          if (cnt_q != '0) begin
            d_q     <= shreg_q[WIDTH-2];
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q - CNT_W'(1);
            state_q <= S_SETUP;
          end else begin
            // Last bit: d keeps its value through the done cycle.
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          d_q     <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign d    = d_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_latch_tx.sv
// ============================================================================
// Module   : tb_serial_latch_tx
// Purpose  : Directed, table-driven bench for serial_latch_tx (WIDTH 8 and 4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_latch_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] data8;
  logic [3:0] data4;
  logic       d8, en8, busy8, done8;
  logic       d4, en4, busy4, done4;

  int checks   = 0;
  int failures = 0;

  logic en8_prev = 1'b0, d8_prev = 1'b0;
  logic en4_prev = 1'b0, d4_prev = 1'b0;

  serial_latch_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .data_in(data8),
    .d(d8), .en(en8), .busy(busy8), .done(done8)
  );

  serial_latch_tx #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .data_in(data4),
    .d(d4), .en(en4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [0:7] seq;   // seq[0] is the first bit expected on the wire
    string      name;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and run the always-on latch checks.
  task automatic tick();
    @(negedge clk);
    if (en8) begin
      check("en8_not_twice", int'(en8_prev), 0);
      check("d8_stable_under_en", int'(d8), int'(d8_prev));
    end
    if (en4) begin
      check("en4_not_twice", int'(en4_prev), 0);
      check("d4_stable_under_en", int'(d4), int'(d4_prev));
    end
    en8_prev = en8; d8_prev = d8;
    en4_prev = en4; d4_prev = d4;
  endtask

  task automatic check_idle8(input string name);
    check({name, "_busy"}, int'(busy8), 0);
    check({name, "_en"},   int'(en8),   0);
    check({name, "_done"}, int'(done8), 0);
    check({name, "_d"},    int'(d8),    0);
  endtask

  // Entered at the falling edge of cycle 1 of a WIDTH=8 frame; returns at
  // the falling edge of cycle 18. If glitch_cyc != 0, start is pulsed with
  // 8'hFF during that cycle.
  task automatic frame_body8(input logic [0:7] seq, input string name,
                             input int glitch_cyc);
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) tick();
      if (glitch_cyc != 0 && c == glitch_cyc) begin
        start8 = 1'b1; data8 = 8'hFF;
      end else if (glitch_cyc != 0 && c == glitch_cyc + 1) begin
        start8 = 1'b0;
      end
      check({name, "_busy"}, int'(busy8), 1);
      check({name, "_en"},   int'(en8),   (c % 2 == 0 && c <= 16) ? 1 : 0);
      check({name, "_done"}, int'(done8), (c == 17) ? 1 : 0);
      if (c <= 16) check({name, "_d"}, int'(d8), int'(seq[(c - 1) / 2]));
      else         check({name, "_d_last"}, int'(d8), int'(seq[7]));
    end
    tick();
  endtask

  task automatic run_frame8(input logic [7:0] data, input logic [0:7] seq,
                            input string name, input int glitch_cyc);
    check_idle8({name, "_pre"});
    start8 = 1'b1;
    data8  = data;
    tick();
    start8 = 1'b0;
    data8  = ~data;   // must not disturb the frame in flight
    frame_body8(seq, name, glitch_cyc);
    check_idle8({name, "_post"});
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{data: 8'hA5, seq: 8'b1010_0101, name: "A5"};
    vecs[1] = '{data: 8'h3C, seq: 8'b0011_1100, name: "3C"};
    vecs[2] = '{data: 8'h81, seq: 8'b1000_0001, name: "81"};
    vecs[3] = '{data: 8'h00, seq: 8'b0000_0000, name: "00"};
    vecs[4] = '{data: 8'hFF, seq: 8'b1111_1111, name: "FF"};
    vecs[5] = '{data: 8'h5A, seq: 8'b0101_1010, name: "5A"};

    rst = 1'b1; start8 = 1'b0; start4 = 1'b0; data8 = 8'h00; data4 = 4'h0;
    tick(); tick();
    check_idle8("reset8");
    check("reset4_busy", int'(busy4), 0);
    check("reset4_d",    int'(d4),    0);
    rst = 1'b0;
    tick();

    // Table-driven frames at WIDTH=8
    foreach (vecs[i]) begin
      run_frame8(vecs[i].data, vecs[i].seq, vecs[i].name, 0);
    end

    // start pulsed with FF during the second strobe of a 3C frame
    run_frame8(8'h3C, 8'b0011_1100, "glitch", 4);
    tick();
    check_idle8("no_second_frame");

    // Async reset during the third strobe (cycle 6)
    start8 = 1'b1; data8 = 8'h3C;
    tick();
    start8 = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    check("rst_pre_en", int'(en8), 1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_en",   int'(en8),   0);
    check("rst_async_busy", int'(busy8), 0);
    check("rst_async_d",    int'(d8),    0);
    check("rst_async_done", int'(done8), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_idle8("rst_hold");
    end
    rst = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      check("rst_no_done", int'(done8), 0);
      check("rst_no_en",   int'(en8),   0);
    end
    run_frame8(8'h81, 8'b1000_0001, "after_rst", 0);

    // start held high: 17 busy cycles then exactly one idle cycle
    start8 = 1'b1; data8 = 8'h0F;
    tick();
    frame_body8(8'b0000_1111, "held1", 0);
    check_idle8("held_gap1");
    tick();
    frame_body8(8'b0000_1111, "held2", 0);
    check_idle8("held_gap2");
    start8 = 1'b0;
    tick();
    check_idle8("held_stop");

    // WIDTH=4: 9 -> 1,0,0,1, done in cycle 9
    check("w4_pre_busy", int'(busy4), 0);
    start4 = 1'b1; data4 = 4'h9;
    tick();
    start4 = 1'b0; data4 = 4'h6;
    begin
      logic [0:3] seq4;
      seq4 = 4'b1001;
      for (int c = 1; c <= 9; c++) begin
        if (c > 1) tick();
        check("w4_busy", int'(busy4), 1);
        check("w4_en",   int'(en4),   (c % 2 == 0 && c <= 8) ? 1 : 0);
        check("w4_done", int'(done4), (c == 9) ? 1 : 0);
        if (c <= 8) check("w4_d", int'(d4), int'(seq4[(c - 1) / 2]));
      end
    end
    tick();
    check("w4_post_busy", int'(busy4), 0);
    check("w4_post_d",    int'(d4),    0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
